// File: rtl/riscv_fetch_ctrl.sv
// Fetch-stage sequencer: drives the imem request bus, PC / F/D register controls,
// and discards responses made stale by redirects. Optional perf counters: FETCH_CTRL_PERF_EN.
module riscv_fetch_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pcf,
    input  logic            i_pc_src_e,
    input  logic            i_hz_stall_f,
    input  logic            i_hz_stall_d,
    input  logic            i_hz_flush_d,
    output logic            o_pc_en,
    output logic            o_fd_en,
    output logic            o_fd_clr,
    output logic [XLEN-1:0] o_instr_f,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [31:0]     o_perf_bubble_cnt,
    output logic [31:0]     o_perf_drop_cnt
);

    typedef enum logic [2:0] {StRst, StReq, StWait, StDrop, StHold} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            stall;
    logic            deliver;

    assign stall = i_hz_stall_f | i_hz_stall_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StRst;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StRst: state_d = StReq;
            StReq: begin
                // A grant alongside a redirect fetched the old PC; its response must be dropped.
                if (i_imem_gnt) state_d = i_pc_src_e ? StDrop : StWait;
            end
            StWait: begin
                if (i_pc_src_e) begin
                    state_d = i_imem_rvalid ? StReq : StDrop;
                end else if (i_imem_rvalid) begin
                    if (stall) begin
                        hold_d  = i_imem_rdata;
                        state_d = StHold;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StDrop: if (i_imem_rvalid) state_d = StReq;
            StHold: if (i_pc_src_e || !stall) state_d = StReq;
            default: state_d = StRst;
        endcase
    end

    always_comb begin
        o_imem_req  = 1'b0;
        o_imem_addr = '0;
        o_pc_en     = 1'b0;
        o_instr_f   = '0;
        o_fd_clr    = 1'b0;
        deliver     = 1'b0;
        unique case (state_q)
            StRst: o_fd_clr = 1'b1;
            StReq: begin
                o_imem_req = ~i_pc_src_e | i_imem_gnt;
                o_pc_en    = i_pc_src_e;
            end
            StWait: begin
                o_instr_f = i_imem_rdata;
                if (i_pc_src_e) begin
                    o_pc_en = 1'b1;
                end else if (i_imem_rvalid && !stall) begin
                    deliver = 1'b1;
                    o_pc_en = 1'b1;
                end
            end
            StDrop: o_pc_en = i_pc_src_e;
            StHold: begin
                o_instr_f = hold_q;
                if (i_pc_src_e) begin
                    o_pc_en = 1'b1;
                end else if (!stall) begin
                    deliver = 1'b1;
                    o_pc_en = 1'b1;
                end
            end
            default: o_fd_clr = 1'b1;
        endcase
        if (state_q != StRst) begin
            o_imem_addr = i_pcf;
            // Insert a bubble whenever decode would otherwise re-latch stale data.
            o_fd_clr    = (~i_hz_stall_d & ~deliver) | i_hz_flush_d | i_pc_src_e;
        end
    end

    assign o_fd_en = deliver;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] bubble_cnt_q, drop_cnt_q;
    logic        drop_evt;

    assign drop_evt = ((state_q == StDrop) && i_imem_rvalid) ||
                      ((state_q == StWait) && i_imem_rvalid && i_pc_src_e) ||
                      ((state_q == StHold) && i_pc_src_e);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bubble_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            if (o_fd_clr && (state_q != StRst) && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (drop_evt && (drop_cnt_q != 32'hFFFF_FFFF)) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    assign o_perf_bubble_cnt = bubble_cnt_q;
    assign o_perf_drop_cnt   = drop_cnt_q;
`else
    assign o_perf_bubble_cnt = 32'd0;
    assign o_perf_drop_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Bench for riscv_fetch_ctrl: directed scenarios plus randomized traffic, all checked
// against a transaction-level model (outstanding / stale / held-instruction flags).
module tb_riscv_fetch_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_pcf = '0;
    logic        i_pc_src_e = 1'b0;
    logic        i_hz_stall_f = 1'b0;
    logic        i_hz_stall_d = 1'b0;
    logic        i_hz_flush_d = 1'b0;
    logic        o_pc_en, o_fd_en, o_fd_clr, o_imem_req;
    logic [31:0] o_instr_f, o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic [31:0] o_perf_bubble_cnt, o_perf_drop_cnt;

    riscv_fetch_ctrl #(.XLEN(32)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_pcf            (i_pcf),
        .i_pc_src_e       (i_pc_src_e),
        .i_hz_stall_f     (i_hz_stall_f),
        .i_hz_stall_d     (i_hz_stall_d),
        .i_hz_flush_d     (i_hz_flush_d),
        .o_pc_en          (o_pc_en),
        .o_fd_en          (o_fd_en),
        .o_fd_clr         (o_fd_clr),
        .o_instr_f        (o_instr_f),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_gnt       (i_imem_gnt),
        .i_imem_rvalid    (i_imem_rvalid),
        .i_imem_rdata     (i_imem_rdata),
        .o_perf_bubble_cnt(o_perf_bubble_cnt),
        .o_perf_drop_cnt  (o_perf_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    // Model: transaction-level view of the fetch stage.
    logic        rst_ph = 1'b1;  // first cycle after reset: bubble only
    logic        outst = 1'b0;   // granted request awaiting its response
    logic        stale = 1'b0;   // that response belongs to a redirected path
    logic        held = 1'b0;    // a response is parked waiting for stalls to clear
    logic [31:0] held_val = '0;
    int          m_bubbles = 0;
    int          m_drops = 0;
    logic        force_rv = 1'b0;

    int          fd_en_seen = 0;
    logic        last_pc_en, last_fd_en, last_fd_clr, last_req;
    logic [31:0] last_addr, last_instr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic src, input logic sf, input logic sd,
                        input logic fl, input logic g, input logic rv,
                        input logic [31:0] pc, input logic [31:0] rd);
        logic        requesting, stl, e_req, e_pc_en, e_fd_en, e_fd_clr, drp;
        logic [31:0] e_instr, e_addr;
        requesting    = !rst_ph && !outst && !held;
        i_rst         = rst;
        i_pc_src_e    = src;
        i_hz_stall_f  = sf;
        i_hz_stall_d  = sd;
        i_hz_flush_d  = fl;
        i_imem_gnt    = g && requesting;
        i_imem_rvalid = rv && (outst || force_rv);
        i_pcf         = pc;
        i_imem_rdata  = rd;
        stl = sf || sd;
        e_req = 1'b0; e_pc_en = 1'b0; e_fd_en = 1'b0; e_fd_clr = 1'b0; drp = 1'b0;
        e_instr = '0; e_addr = '0;
        if (rst_ph) begin
            e_fd_clr = 1'b1;
        end else begin
            e_addr = pc;
            if (requesting) begin
                e_req   = !src || i_imem_gnt;
                e_pc_en = src;
            end else if (held) begin
                if (src) begin
                    e_pc_en = 1'b1;
                    drp = 1'b1;
                end else if (!stl) begin
                    e_fd_en = 1'b1; e_pc_en = 1'b1; e_instr = held_val;
                end
            end else if (stale) begin
                e_pc_en = src;
                drp = i_imem_rvalid;
            end else begin
                if (src) begin
                    e_pc_en = 1'b1;
                    drp = i_imem_rvalid;
                end else if (i_imem_rvalid && !stl) begin
                    e_fd_en = 1'b1; e_pc_en = 1'b1; e_instr = rd;
                end
            end
            e_fd_clr = (!sd && !e_fd_en) || fl || src;
        end
        #3;
        check("imem_req", {31'd0, o_imem_req}, {31'd0, e_req});
        check("imem_addr", o_imem_addr, e_addr);
        check("pc_en", {31'd0, o_pc_en}, {31'd0, e_pc_en});
        check("fd_en", {31'd0, o_fd_en}, {31'd0, e_fd_en});
        check("fd_clr", {31'd0, o_fd_clr}, {31'd0, e_fd_clr});
        if (e_fd_en) check("instr_f", o_instr_f, e_instr);
`ifdef FETCH_CTRL_PERF_EN
        check("perf_bubble", o_perf_bubble_cnt, m_bubbles);
        check("perf_drop", o_perf_drop_cnt, m_drops);
`else
        check("perf_bubble_tied", o_perf_bubble_cnt, 32'd0);
        check("perf_drop_tied", o_perf_drop_cnt, 32'd0);
`endif
        if (o_fd_en === 1'b1) fd_en_seen++;
        last_pc_en = o_pc_en; last_fd_en = o_fd_en; last_fd_clr = o_fd_clr;
        last_req = o_imem_req; last_addr = o_imem_addr; last_instr = o_instr_f;
        // Advance the model across the coming edge.
        if (!rst_ph && e_fd_clr) m_bubbles++;
        if (drp) m_drops++;
        if (rst) begin
            rst_ph = 1'b1; outst = 1'b0; stale = 1'b0; held = 1'b0;
            m_bubbles = 0; m_drops = 0;
        end else if (rst_ph) begin
            rst_ph = 1'b0;
        end else if (requesting) begin
            if (i_imem_gnt) begin
                outst = 1'b1;
                stale = src;
            end
        end else if (held) begin
            if (src || !stl) held = 1'b0;
        end else if (outst) begin
            if (i_imem_rvalid) begin
                outst = 1'b0;
                if (!stale && !src && stl) begin
                    held = 1'b1;
                    held_val = rd;
                end
            end else if (src) begin
                stale = 1'b1;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        // Bring the DUT out of an unknown state.
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        rst_ph = 1'b1;

        // Reset cycle: only the bubble is asserted.
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("rst_fd_clr", {31'd0, last_fd_clr}, 32'd1);
        check("rst_req", {31'd0, last_req}, 32'd0);

        // Zero-wait memory: one instruction every two cycles.
        fd_en_seen = 0;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 1, 1, 32'h4 * i, 32'h0000_0013);
        check("zero_wait_rate", fd_en_seen, 32'd5);

        // Grant delayed 3 cycles: request and address held.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, (i == 3), 0, 32'h100, 32'h0);
            check("gnt_wait_req", {31'd0, last_req}, 32'd1);
            check("gnt_wait_addr", last_addr, 32'h100);
        end
        step(0, 0, 0, 0, 0, 0, 0, 32'h100, 32'h0);
        check("in_wait_no_req", {31'd0, last_req}, 32'd0);

        // Redirect before the response: response must never reach decode.
        step(0, 1, 0, 0, 0, 0, 0, 32'h100, 32'h0);
        check("redirect_pc_en", {31'd0, last_pc_en}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 32'h200, 32'h0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h200, 32'hDEAD_BEEF);
        check("drop_no_fd_en", {31'd0, last_fd_en}, 32'd0);

        // Response under decode stall is parked and delivered once on release.
        step(0, 0, 0, 0, 0, 1, 0, 32'h200, 32'h0);
        fd_en_seen = 0;
        step(0, 0, 0, 1, 0, 0, 1, 32'h200, 32'h1234_5678);
        step(0, 0, 0, 1, 0, 0, 0, 32'h200, 32'h0);
        step(0, 0, 0, 1, 0, 0, 0, 32'h200, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h200, 32'h0);
        check("hold_release_en", {31'd0, last_fd_en}, 32'd1);
        check("hold_release_data", last_instr, 32'h1234_5678);
        check("hold_single_delivery", fd_en_seen, 32'd1);

        // Flush beats stall.
        step(0, 0, 0, 1, 1, 0, 0, 32'h204, 32'h0);
        check("flush_stall_clr", {31'd0, last_fd_clr}, 32'd1);
        check("flush_stall_en", {31'd0, last_fd_en}, 32'd0);

        // Reset while a response is outstanding; the late response is ignored.
        step(0, 0, 0, 0, 0, 1, 0, 32'h204, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h204, 32'h0);
        force_rv = 1'b1;
        step(0, 0, 0, 0, 0, 0, 1, 32'h204, 32'h0000_0BAD);
        force_rv = 1'b0;
        check("rst_late_rv_fd_en", {31'd0, last_fd_en}, 32'd0);
        check("rst_late_rv_pc_en", {31'd0, last_pc_en}, 32'd0);
        fd_en_seen = 0;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0000_0013);
        check("resume_after_rst", fd_en_seen, 32'd3);

        // Randomized traffic with hazards, redirects and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 50,
                 $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_ctrl.md
# riscv_fetch_ctrl

Sequencer for the pipelined fetch stage in front of a variable-latency instruction memory. It drives the request/grant/response bus, and generates the PC-register and F/D-register enable/clear controls. It merges hazard-unit stall/flush requests with memory wait states and execute-stage redirects, and discards responses made stale by a redirect. It sits between the hazard unit, the fetch datapath (PC mux, PC register, F/D register) and the instruction memory.

## Interface
- XLEN, 32, datapath/address width (matches `XLEN).
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_pcf  in  XLEN  current PC register value.
- i_pc_src_e  in  1  execute-stage redirect; PC mux selects target this cycle.
- i_hz_stall_f  in  1  hazard unit: hold PC.
- i_hz_stall_d  in  1  hazard unit: hold F/D register.
- i_hz_flush_d  in  1  hazard unit: clear F/D register.
- o_pc_en  out  1  PC register load enable.
- o_fd_en  out  1  F/D register load enable.
- o_fd_clr  out  1  F/D register synchronous clear (bubble).
- o_instr_f  out  XLEN  instruction presented to F/D register input.
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  XLEN  fetch address, equals i_pcf.
- i_imem_gnt  in  1  request accepted this cycle.
- i_imem_rvalid  in  1  response valid; at most one outstanding.
- i_imem_rdata  in  XLEN  response instruction.
- o_perf_bubble_cnt  out  32  fetch-bubble counter (see Configuration).
- o_perf_drop_cnt  out  32  discarded-response counter (see Configuration).

## Operation
- States: RST, REQ, WAIT, DROP, HOLD. Registers: state, XLEN-bit hold buffer.
- RST: entered on i_rst; all outputs 0 except o_fd_clr=1. Next state is REQ.
- REQ: o_imem_req=1.
  - gnt → WAIT.
  - i_pc_src_e without gnt: req forced 0 this cycle, o_pc_en=1, stay REQ.
  - i_pc_src_e with gnt: o_pc_en=1 → DROP.
- WAIT:
  - rvalid, no stall, no redirect: o_instr_f=rdata, o_fd_en=1, o_pc_en=1 → REQ.
  - rvalid while i_hz_stall_d or i_hz_stall_f: capture rdata in buffer → HOLD.
  - rvalid with i_pc_src_e: response discarded, o_pc_en=1 → REQ.
  - i_pc_src_e without rvalid: o_pc_en=1 → DROP.
- DROP: on rvalid → REQ; data never reaches F/D. Redirect in DROP: o_pc_en=1, stay DROP.
- HOLD:
  - Stalls released: o_instr_f=buffer, o_fd_en=1, o_pc_en=1 → REQ.
  - i_pc_src_e: buffer discarded, o_pc_en=1 → REQ.
- Bubbles: o_fd_clr=1 when decode is not stalled and no instruction is delivered this cycle, or when i_hz_flush_d or i_pc_src_e. Flush beats stall.
- o_pc_en is never 1 while i_hz_stall_f=1 unless i_pc_src_e=1. Redirect always wins.

## Timing
- Bus rules:
  - o_imem_addr is stable while req=1 and gnt=0.
  - Only one request is outstanding.
  - rvalid is never earlier than the cycle after gnt.
- Zero-wait memory (gnt same cycle, rvalid next): 1 instruction per 2 cycles. Each extra rvalid latency cycle adds 1.
- Delivered instruction: o_fd_en and o_instr_f in the rvalid cycle (WAIT) or the release cycle (HOLD). F/D updates on the next edge.
- Reset mid-transaction: the outstanding response after reset is ignored (RST/REQ do not look at rvalid).

## Configuration
- FETCH_CTRL_PERF_EN defined:
  - o_perf_bubble_cnt increments on every o_fd_clr=1 cycle outside RST.
  - o_perf_drop_cnt increments on each discarded response: rvalid in DROP, rvalid with redirect in WAIT, or redirect in HOLD.
  - Both counters saturate at 32'hFFFF_FFFF and clear on i_rst.
- Not defined: both ports tied to 0; no counter flops.

## Test plan
- Reset, zero-wait memory with rdata=32'h0000_0013 each fetch, no hazards → o_fd_en pulses every 2nd cycle; o_pc_en coincides with o_fd_en; first req in the cycle after reset release.
- gnt delayed 3 cycles with i_pcf=32'h100 → req held and o_imem_addr stays 32'h100 for 4 cycles; state WAIT after gnt.
- Redirect in WAIT before rvalid (rvalid 2 cycles later, rdata=32'hDEAD_BEEF) → o_pc_en=1 on redirect; DEAD_BEEF never has o_fd_en=1; o_perf_drop_cnt=1 with macro.
- rvalid with i_hz_stall_d high for 3 cycles → HOLD; on release o_instr_f equals captured rdata, o_fd_en=1 once.
- i_hz_flush_d and i_hz_stall_d together → o_fd_clr=1, o_fd_en=0.
- Assert i_rst in WAIT, then return rvalid → no o_fd_en; all outputs at reset values; normal fetch resumes.
